// File: rtl/boreal_ads_pkg.sv
// Shared types and frame constants for the ADS1299 acquisition path.
// Imported by the frame reader and its interface users.
package boreal_ads_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        SHIFT,
        CS_HOLD,
        PUBLISH
    } state_t;

    localparam int STATUS_BITS = 24;
    localparam int CH_BITS     = 24;
    localparam int FRAME_BITS  = 216;
    localparam logic [3:0] STATUS_HDR = 4'hC;

endpackage

// File: rtl/ads1299_frame_reader_if.sv
// SPI link between the frame reader (master) and the ADS1299 (slave).
// DRDY travels with the bus since it frames every read.
interface ads1299_frame_reader_if;

    logic ads_drdy_n;
    logic ads_miso;
    logic ads_sclk;
    logic ads_cs_n;

    modport master (
        input  ads_drdy_n,
        input  ads_miso,
        output ads_sclk,
        output ads_cs_n
    );

    modport slave (
        output ads_drdy_n,
        output ads_miso,
        input  ads_sclk,
        input  ads_cs_n
    );

endinterface

// File: rtl/boreal_sync_fall.sv
// Two-flop synchronizer with a one-cycle falling-edge pulse.
// Flops reset high so an idle-high strobe never fires out of reset.
module boreal_sync_fall (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic fall
);

    // sr[1] is the synchronized level, sr[2] its previous value
    logic [2:0] sr;

    always_ff @(posedge clk) begin
        if (!rst_n) sr <= '1;
        else        sr <= {sr[1:0], async_in};
    end

    assign fall = sr[2] & ~sr[1];

endmodule

// File: rtl/ads1299_frame_reader.sv
// Reads one full ADS1299 RDATA frame per DRDY and publishes
// all channels as one word with a single-cycle valid.
module ads1299_frame_reader
    import boreal_ads_pkg::*;
#(
    parameter int SCLK_DIV     = 4,
    parameter int CS_SETUP_CYC = 4,
    parameter int CS_HOLD_CYC  = 4,
    parameter int N_CH         = 8
) (
    input  logic                      clk_100m,
    input  logic                      rst_n,
    input  logic                      enable,
    ads1299_frame_reader_if.master    spi,
    output logic [CH_BITS*N_CH-1:0]   raw8,
    output logic [STATUS_BITS-1:0]    status,
    output logic                      frame_valid,
    output logic                      frame_err,
    output logic                      overrun,
    output logic                      busy
);

    localparam logic [7:0] HALF_LAST  = 8'(SCLK_DIV - 1);
    localparam logic [7:0] SETUP_LAST = 8'(CS_SETUP_CYC - 1);
    localparam logic [7:0] HOLD_LAST  = 8'(CS_HOLD_CYC - 1);
    localparam logic [7:0] BIT_LAST   = 8'(FRAME_BITS - 1);

    state_t state, state_nxt;

    logic                  drdy_fall;
    logic                  sclk_q;
    logic                  cs_n_q;
    logic [7:0]            cnt;
    logic [7:0]            half;
    logic [7:0]            bitc;
    logic [FRAME_BITS-1:0] shreg;
    logic                  half_done;
    logic                  hdr_ok;

    boreal_sync_fall u_drdy (
        .clk      (clk_100m),
        .rst_n    (rst_n),
        .async_in (spi.ads_drdy_n),
        .fall     (drdy_fall)
    );

    assign half_done = (half == HALF_LAST);
    assign hdr_ok    = (shreg[FRAME_BITS-1 -: 4] == STATUS_HDR);

    always_ff @(posedge clk_100m) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:     if (drdy_fall && enable)        state_nxt = CS_SETUP;
            CS_SETUP: if (cnt == SETUP_LAST)          state_nxt = SHIFT;
            SHIFT:    if (half_done && sclk_q &&
                          bitc == BIT_LAST)           state_nxt = CS_HOLD;
            CS_HOLD:  if (cnt == HOLD_LAST)           state_nxt = PUBLISH;
            PUBLISH:                                  state_nxt = IDLE;
            default:                                  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_100m) begin
        if (!rst_n) begin
            sclk_q      <= 1'b0;
            cs_n_q      <= 1'b1;
            cnt         <= '0;
            half        <= '0;
            bitc        <= '0;
            shreg       <= '0;
            raw8        <= '0;
            status      <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (state_nxt == CS_SETUP) begin
                        cs_n_q <= 1'b0;
                        cnt    <= '0;
                    end
                end
                CS_SETUP: begin
                    if (cnt == SETUP_LAST) begin
                        sclk_q <= 1'b1;
                        half   <= '0;
                        bitc   <= '0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                SHIFT: begin
                    if (half_done) begin
                        half   <= '0;
                        sclk_q <= ~sclk_q;
                        // MISO sampled on the edge that drops SCLK
                        if (sclk_q) begin
                            shreg <= {shreg[FRAME_BITS-2:0], spi.ads_miso};
                            bitc  <= bitc + 8'd1;
                            cnt   <= '0;
                        end
                    end else begin
                        half <= half + 8'd1;
                    end
                end
                CS_HOLD: begin
                    if (cnt == HOLD_LAST) cs_n_q <= 1'b1;
                    else                  cnt    <= cnt + 8'd1;
                end
                PUBLISH: begin
                    if (hdr_ok) begin
                        status <= shreg[FRAME_BITS-1 -: STATUS_BITS];
                        for (int k = 0; k < N_CH; k++) begin
                            raw8[CH_BITS*k +: CH_BITS] <=
                                shreg[FRAME_BITS-STATUS_BITS-1-CH_BITS*k -: CH_BITS];
                        end
                        frame_valid <= 1'b1;
                    end else begin
                        frame_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign spi.ads_sclk = sclk_q;
    assign spi.ads_cs_n = cs_n_q;
    assign busy         = (state != IDLE);
    assign overrun      = drdy_fall && (state != IDLE);

endmodule

// File: tb/tb_ads1299_frame_reader.sv
// Bench for ads1299_frame_reader: an ADS1299 DOUT model driven from a
// frame table, with a scoreboard of expected publishes.
module tb_ads1299_frame_reader;

    logic         clk_100m = 1'b0;
    logic         rst_n    = 1'b0;
    logic         enable   = 1'b0;
    logic [191:0] raw8;
    logic [23:0]  status;
    logic         frame_valid, frame_err, overrun, busy;

    always #5 clk_100m = ~clk_100m;

    ads1299_frame_reader_if spi ();

    ads1299_frame_reader dut (
        .clk_100m    (clk_100m),
        .rst_n       (rst_n),
        .enable      (enable),
        .spi         (spi),
        .raw8        (raw8),
        .status      (status),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
        .overrun     (overrun),
        .busy        (busy)
    );

    typedef struct packed {
        logic [23:0]       st;
        logic [7:0][23:0]  ch;
        logic              good;
        logic [191:0]      exp_raw;
        logic [23:0]       exp_st;
    } vec_t;

    typedef struct packed {
        logic         good;
        logic [191:0] raw;
        logic [23:0]  st;
    } exp_t;

    vec_t tbl [4];
    exp_t sbq [$];

    int checks = 0;
    int errors = 0;

    logic [215:0] frame_bits = '0;
    int bit_idx = 215;

    int cyc = 0, c_cyc = 0, first_rise = -1, last_fall = 0;
    int nfall = 0, per_bad = 0, cs_falls = 0;
    int pub_cnt = 0, ov_cnt = 0, busy_cnt = 0;
    logic prev_cs = 1'b1, prev_sclk = 1'b0;

    function automatic void check(string nm, logic [191:0] act, logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endfunction

    function automatic void timeout(string nm);
        checks++;
        errors++;
        $display("FAIL %s: timeout", nm);
    endfunction

    always @(posedge clk_100m) cyc++;

    // ADS1299 DOUT: next bit presented on each SCLK rise (CPHA=1)
    always @(negedge spi.ads_cs_n) bit_idx = 215;
    always @(posedge spi.ads_sclk) begin
        spi.ads_miso = (bit_idx >= 0) ? frame_bits[bit_idx] : 1'b0;
        bit_idx--;
    end

    always @(negedge clk_100m) begin
        exp_t e;
        if (prev_cs && !spi.ads_cs_n) begin
            c_cyc = cyc;
            nfall = 0;
            per_bad = 0;
            first_rise = -1;
            cs_falls++;
        end
        if (!prev_sclk && spi.ads_sclk && first_rise < 0) first_rise = cyc;
        if (prev_sclk && !spi.ads_sclk) begin
            if (nfall > 0 && cyc - last_fall != 8) per_bad++;
            last_fall = cyc;
            nfall++;
        end
        if (overrun) ov_cnt++;
        if (busy) busy_cnt++;
        if (frame_valid || frame_err) begin
            pub_cnt++;
            if (sbq.size() == 0) begin
                check("sb_unexpected", {frame_err, frame_valid}, 2'b00);
            end else begin
                e = sbq.pop_front();
                check("sb_kind", {frame_err, frame_valid}, e.good ? 2'b01 : 2'b10);
                check("sb_raw8", raw8, e.raw);
                check("sb_status", status, e.st);
                check("sb_latency", cyc - c_cyc, 1733);
            end
        end
        prev_cs   = spi.ads_cs_n;
        prev_sclk = spi.ads_sclk;
    end

    task automatic drdy_pulse();
        @(negedge clk_100m) spi.ads_drdy_n = 1'b0;
        repeat (4) @(negedge clk_100m);
        spi.ads_drdy_n = 1'b1;
    endtask

    task automatic run_frame(input vec_t v, input bit push);
        exp_t e;
        frame_bits[215:192] = v.st;
        for (int k = 0; k < 8; k++) frame_bits[191-24*k -: 24] = v.ch[k];
        if (push) begin
            e.good = v.good;
            e.raw  = v.exp_raw;
            e.st   = v.exp_st;
            sbq.push_back(e);
        end
        drdy_pulse();
    endtask

    task automatic wait_pub(input int n0);
        int t = 0;
        while (pub_cnt == n0 && t < 4000) begin
            @(negedge clk_100m);
            t++;
        end
        if (t >= 4000) timeout("wait_pub");
    endtask

    task automatic wait_falls(input int n);
        int t = 0;
        while (nfall < n && t < 3000) begin
            @(negedge clk_100m);
            t++;
        end
        if (t >= 3000) timeout("wait_falls");
    endtask

    initial begin
        int n0, ov0, cs0;

        tbl[0].st      = 24'hC00000;
        tbl[0].ch      = {24'h800008, 24'h700007, 24'h600006, 24'h500005,
                          24'h400004, 24'h300003, 24'h200002, 24'h100001};
        tbl[0].good    = 1'b1;
        tbl[0].exp_raw = {24'h800008, 24'h700007, 24'h600006, 24'h500005,
                          24'h400004, 24'h300003, 24'h200002, 24'h100001};
        tbl[0].exp_st  = 24'hC00000;

        tbl[1].st      = 24'h800000;
        tbl[1].ch      = {8{24'h123456}};
        tbl[1].good    = 1'b0;
        tbl[1].exp_raw = tbl[0].exp_raw;
        tbl[1].exp_st  = 24'hC00000;

        tbl[2].st      = 24'hC12345;
        tbl[2].ch      = {{6{24'h000000}}, 24'h800000, 24'hFFFFFF};
        tbl[2].good    = 1'b1;
        tbl[2].exp_raw = {144'h0, 24'h800000, 24'hFFFFFF};
        tbl[2].exp_st  = 24'hC12345;

        tbl[3].st      = 24'hCA5A5A;
        tbl[3].ch      = {24'h000001, 24'h7FFFFF, 24'hABCDEF, 24'h123456,
                          24'h0F0F0F, 24'hF0F0F0, 24'h55AA55, 24'h800001};
        tbl[3].good    = 1'b1;
        tbl[3].exp_raw = {24'h000001, 24'h7FFFFF, 24'hABCDEF, 24'h123456,
                          24'h0F0F0F, 24'hF0F0F0, 24'h55AA55, 24'h800001};
        tbl[3].exp_st  = 24'hCA5A5A;

        spi.ads_drdy_n = 1'b1;
        repeat (5) @(negedge clk_100m);
        check("rst_sclk", spi.ads_sclk, 1'b0);
        check("rst_cs_n", spi.ads_cs_n, 1'b1);
        check("rst_raw8", raw8, '0);
        check("rst_status", status, '0);
        check("rst_valid", frame_valid, 1'b0);
        check("rst_err", frame_err, 1'b0);
        check("rst_overrun", overrun, 1'b0);
        check("rst_busy", busy, 1'b0);
        rst_n  = 1'b1;
        enable = 1'b1;
        repeat (5) @(negedge clk_100m);

        for (int i = 0; i < 4; i++) begin
            n0  = pub_cnt;
            ov0 = ov_cnt;
            run_frame(tbl[i], 1'b1);
            wait_pub(n0);
            check("sclk_falls", nfall, 216);
            check("sclk_period", per_bad, 0);
            check("first_rise", first_rise - c_cyc, 4);
            check("no_overrun", ov_cnt - ov0, 0);
            repeat (20) @(negedge clk_100m);
        end

        // second DRDY mid-shift: dropped, flagged once
        n0  = pub_cnt;
        ov0 = ov_cnt;
        run_frame(tbl[0], 1'b1);
        wait_falls(100);
        drdy_pulse();
        wait_pub(n0);
        repeat (30) @(negedge clk_100m);
        check("ovr_count", ov_cnt - ov0, 1);
        check("ovr_pubs", pub_cnt - n0, 1);

        // reset in the middle of the shift phase
        run_frame(tbl[2], 1'b0);
        wait_falls(50);
        @(negedge clk_100m) rst_n = 1'b0;
        @(posedge clk_100m);
        #1;
        check("mrst_cs_n", spi.ads_cs_n, 1'b1);
        check("mrst_sclk", spi.ads_sclk, 1'b0);
        check("mrst_raw8", raw8, '0);
        check("mrst_status", status, '0);
        check("mrst_busy", busy, 1'b0);
        check("mrst_pulses", {frame_valid, frame_err}, 2'b00);
        n0 = pub_cnt;
        @(negedge clk_100m) rst_n = 1'b1;
        repeat (1800) @(negedge clk_100m);
        check("mrst_nopub", pub_cnt - n0, 0);
        run_frame(tbl[3], 1'b1);
        wait_pub(n0);
        check("mrst_falls", nfall, 216);
        repeat (20) @(negedge clk_100m);

        // disabled: DRDY ignored
        enable   = 1'b0;
        cs0      = cs_falls;
        busy_cnt = 0;
        n0       = pub_cnt;
        ov0      = ov_cnt;
        drdy_pulse();
        repeat (60) @(negedge clk_100m);
        check("dis_cs", cs_falls - cs0, 0);
        check("dis_busy", busy_cnt, 0);
        check("dis_pubs", pub_cnt - n0, 0);
        check("dis_ovr", ov_cnt - ov0, 0);
        enable = 1'b1;
        run_frame(tbl[0], 1'b1);
        wait_pub(n0);
        repeat (20) @(negedge clk_100m);

        // enable dropped mid-frame: frame still completes
        n0 = pub_cnt;
        run_frame(tbl[2], 1'b1);
        wait_falls(20);
        enable = 1'b0;
        wait_pub(n0);
        enable = 1'b1;
        repeat (20) @(negedge clk_100m);

        check("sb_drained", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
